// File: rtl/reg_scoreboard_if.sv
// Issue/ready/writeback/flush events in, operand lookups and scoreboard status out.
interface reg_scoreboard_if;
    logic       issue_valid;
    logic       issue_we;
    logic [4:0] issue_waddr;
    logic       issue_late;
    logic       ready_valid;
    logic [4:0] ready_waddr;
    logic       wb_valid;
    logic       wb_we;
    logic [4:0] wb_waddr;
    logic       flush;
    logic [4:0] raddr1;
    logic [4:0] raddr2;
    logic       rs1_busy;
    logic       rs2_busy;
    logic       stall;
    logic [2:0] inflight;
    logic       err;

    modport master (
        output issue_valid, issue_we, issue_waddr, issue_late,
        output ready_valid, ready_waddr,
        output wb_valid, wb_we, wb_waddr,
        output flush, raddr1, raddr2,
        input  rs1_busy, rs2_busy, stall, inflight, err
    );

    modport slave (
        input  issue_valid, issue_we, issue_waddr, issue_late,
        input  ready_valid, ready_waddr,
        input  wb_valid, wb_we, wb_waddr,
        input  flush, raddr1, raddr2,
        output rs1_busy, rs2_busy, stall, inflight, err
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register count of in-flight writers (pend) and of
// writers whose result is not yet forwardable (late). Drives operand busy,
// load-use stall, in-flight register count and a sticky error flag.
module reg_scoreboard (
    input  logic            clk,
    input  logic            resetn,
    reg_scoreboard_if.slave sb
);

    // Entry 0 is never written, so it always reads as idle.
    logic [31:0][1:0] pend_q, pend_d;
    logic [31:0][1:0] late_q, late_d;
    logic [2:0]       inflight_q, inflight_d;
    logic             err_q, err_d;

    logic [1:0]       step_p, step_l;
    logic             step_e;
    logic             err_any;
    logic [4:0]       busy_cnt;

    // Net per-register update: retire and ready are judged against the
    // registered counts, late is clamped to pend, then issue is applied on
    // top so a same-cycle retire makes room for a fourth writer.
    function automatic void count_step(
        input  logic [1:0] p,
        input  logic [1:0] l,
        input  logic       iss,
        input  logic       iss_late,
        input  logic       ret,
        input  logic       rdy,
        output logic [1:0] p_n,
        output logic [1:0] l_n,
        output logic       e
    );
        logic [2:0] p1;
        logic [2:0] l1;
        e  = 1'b0;
        p1 = {1'b0, p};
        l1 = {1'b0, l};
        if (ret) begin
            if (p == 2'd0) e = 1'b1;
            else           p1 = p1 - 3'd1;
        end
        if (rdy) begin
            if (l == 2'd0) e = 1'b1;
            else           l1 = l1 - 3'd1;
        end
        if (l1 > p1) begin
            l1 = p1;
            e  = 1'b1;
        end
        if (iss) begin
            if (p1 == 3'd3) begin
                e = 1'b1;
            end else begin
                p1 = p1 + 3'd1;
                if (iss_late) l1 = l1 + 3'd1;
            end
        end
        p_n = p1[1:0];
        l_n = l1[1:0];
    endfunction

    // Next-state for all counters, the error flag and the busy-register count.
    always_comb begin
        pend_d     = '0;
        late_d     = '0;
        err_d      = err_q;
        err_any    = 1'b0;
        step_p     = '0;
        step_l     = '0;
        step_e     = 1'b0;
        busy_cnt   = '0;
        inflight_d = '0;
        for (int unsigned r = 1; r < 32; r++) begin
            count_step(pend_q[r], late_q[r],
                       sb.issue_valid && sb.issue_we && (sb.issue_waddr == 5'(r)),
                       sb.issue_late,
                       sb.wb_valid && sb.wb_we && (sb.wb_waddr == 5'(r)),
                       sb.ready_valid && (sb.ready_waddr == 5'(r)),
                       step_p, step_l, step_e);
            pend_d[r] = step_p;
            late_d[r] = step_l;
            err_any   = err_any | step_e;
        end
        if (sb.flush) begin
            pend_d = '0;
            late_d = '0;
        end else begin
            err_d = err_q | err_any;
        end
        for (int unsigned r = 1; r < 32; r++) begin
            if (pend_d[r] != 2'd0) busy_cnt = busy_cnt + 5'd1;
        end
        inflight_d = (busy_cnt > 5'd7) ? 3'd7 : busy_cnt[2:0];
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_q     <= '0;
            late_q     <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            late_q     <= late_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    assign sb.rs1_busy = (sb.raddr1 != 5'd0) && (pend_q[sb.raddr1] != 2'd0);
    assign sb.rs2_busy = (sb.raddr2 != 5'd0) && (pend_q[sb.raddr2] != 2'd0);
    assign sb.stall    = ((sb.raddr1 != 5'd0) && (late_q[sb.raddr1] != 2'd0)) ||
                         ((sb.raddr2 != 5'd0) && (late_q[sb.raddr2] != 2'd0));
    assign sb.inflight = inflight_q;
    assign sb.err      = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against an integer model.
module tb_reg_scoreboard;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    reg_scoreboard_if sb_if ();

    reg_scoreboard dut (
        .clk    (clk),
        .resetn (resetn),
        .sb     (sb_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: plain integer counts per register.
    int m_pend[32];
    int m_late[32];
    int m_err  = 0;
    int m_infl = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear(input bit clr_err);
        for (int r = 0; r < 32; r++) begin
            m_pend[r] = 0;
            m_late[r] = 0;
        end
        m_infl = 0;
        if (clr_err) m_err = 0;
    endtask

    task automatic model_step();
        int np[32];
        int nl[32];
        int cnt;
        int a;
        if (sb_if.flush) begin
            model_clear(1'b0);
            return;
        end
        np = m_pend;
        nl = m_late;
        a = int'(sb_if.wb_waddr);
        if (sb_if.wb_valid && sb_if.wb_we && a != 0) begin
            if (np[a] == 0) m_err = 1;
            else            np[a] = np[a] - 1;
        end
        a = int'(sb_if.ready_waddr);
        if (sb_if.ready_valid && a != 0) begin
            if (nl[a] == 0) m_err = 1;
            else            nl[a] = nl[a] - 1;
        end
        for (int r = 1; r < 32; r++) begin
            if (nl[r] > np[r]) begin
                nl[r] = np[r];
                m_err = 1;
            end
        end
        a = int'(sb_if.issue_waddr);
        if (sb_if.issue_valid && sb_if.issue_we && a != 0) begin
            if (np[a] >= 3) begin
                m_err = 1;
            end else begin
                np[a] = np[a] + 1;
                if (sb_if.issue_late) nl[a] = nl[a] + 1;
            end
        end
        cnt = 0;
        for (int r = 1; r < 32; r++) if (np[r] != 0) cnt++;
        m_pend = np;
        m_late = nl;
        m_infl = (cnt > 7) ? 7 : cnt;
    endtask

    // Model tracks the DUT edge by edge; reset clears it asynchronously.
    initial begin
        model_clear(1'b1);
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) model_clear(1'b1);
            else         model_step();
        end
    end

    // Every falling edge: all outputs against the model.
    initial begin
        int a1, a2;
        forever begin
            @(negedge clk);
            a1 = int'(sb_if.raddr1);
            a2 = int'(sb_if.raddr2);
            chk("cmp_rs1_busy", int'(sb_if.rs1_busy), (a1 != 0 && m_pend[a1] != 0) ? 1 : 0);
            chk("cmp_rs2_busy", int'(sb_if.rs2_busy), (a2 != 0 && m_pend[a2] != 0) ? 1 : 0);
            chk("cmp_stall", int'(sb_if.stall),
                ((a1 != 0 && m_late[a1] != 0) || (a2 != 0 && m_late[a2] != 0)) ? 1 : 0);
            chk("cmp_inflight", int'(sb_if.inflight), m_infl);
            chk("cmp_err", int'(sb_if.err), m_err);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic idle();
        sb_if.issue_valid = 1'b0;
        sb_if.issue_we    = 1'b0;
        sb_if.issue_waddr = 5'd0;
        sb_if.issue_late  = 1'b0;
        sb_if.ready_valid = 1'b0;
        sb_if.ready_waddr = 5'd0;
        sb_if.wb_valid    = 1'b0;
        sb_if.wb_we       = 1'b0;
        sb_if.wb_waddr    = 5'd0;
        sb_if.flush       = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int r, input bit lt);
        sb_if.issue_valid = 1'b1;
        sb_if.issue_we    = 1'b1;
        sb_if.issue_waddr = 5'(r);
        sb_if.issue_late  = lt;
    endtask

    task automatic retire(input int r);
        sb_if.wb_valid = 1'b1;
        sb_if.wb_we    = 1'b1;
        sb_if.wb_waddr = 5'(r);
    endtask

    task automatic ready(input int r);
        sb_if.ready_valid = 1'b1;
        sb_if.ready_waddr = 5'(r);
    endtask

    function automatic int pick_reg(input bit use_late);
        int q[$];
        for (int r = 1; r < 32; r++)
            if ((use_late ? m_late[r] : m_pend[r]) != 0) q.push_back(r);
        if (q.size() == 0 || $urandom_range(0, 9) == 0) return int'($urandom_range(0, 31));
        return q[$urandom_range(0, q.size() - 1)];
    endfunction

    task automatic do_reset();
        idle();
        resetn = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
    endtask

    initial begin
        idle();
        sb_if.raddr1 = 5'd0;
        sb_if.raddr2 = 5'd0;
        repeat (3) tick();
        resetn = 1'b1;

        chk("reset_rs1_busy", int'(sb_if.rs1_busy), 0);
        chk("reset_stall", int'(sb_if.stall), 0);
        chk("reset_inflight", int'(sb_if.inflight), 0);
        chk("reset_err", int'(sb_if.err), 0);

        // Non-late writer to r5: busy one cycle after issue, clear after retire.
        issue(5, 1'b0);
        sb_if.raddr1 = 5'd5;
        #1 chk("r5_busy_issue_cycle", int'(sb_if.rs1_busy), 0);
        tick(); idle();
        chk("r5_busy_next", int'(sb_if.rs1_busy), 1);
        chk("r5_no_stall", int'(sb_if.stall), 0);
        chk("r5_inflight", int'(sb_if.inflight), 1);
        tick(); tick();
        retire(5);
        #1 chk("r5_busy_wb_cycle", int'(sb_if.rs1_busy), 1);
        tick(); idle();
        chk("r5_busy_after_wb", int'(sb_if.rs1_busy), 0);

        // Late writer to r7: stall until ready, busy until retire.
        issue(7, 1'b1);
        sb_if.raddr2 = 5'd7;
        tick(); idle();
        chk("r7_stall", int'(sb_if.stall), 1);
        chk("r7_busy", int'(sb_if.rs2_busy), 1);
        ready(7);
        #1 chk("r7_stall_ready_cycle", int'(sb_if.stall), 1);
        tick(); idle();
        chk("r7_stall_cleared", int'(sb_if.stall), 0);
        chk("r7_busy_after_ready", int'(sb_if.rs2_busy), 1);
        tick();
        retire(7);
        tick(); idle();
        chk("r7_busy_after_wb", int'(sb_if.rs2_busy), 0);
        chk("r7_err", int'(sb_if.err), 0);

        // Same-cycle issue and retire of r3 nets to no change.
        issue(3, 1'b0);
        sb_if.raddr1 = 5'd3;
        sb_if.raddr2 = 5'd0;
        tick(); idle();
        issue(3, 1'b0);
        retire(3);
        tick(); idle();
        chk("r3_busy_net", int'(sb_if.rs1_busy), 1);
        chk("r3_err_net", int'(sb_if.err), 0);
        chk("r3_inflight_net", int'(sb_if.inflight), 1);
        retire(3);
        tick(); idle();
        chk("r3_busy_done", int'(sb_if.rs1_busy), 0);
        chk("r3_inflight_done", int'(sb_if.inflight), 0);

        // Flush discards r1, r2 (late) and r4 and beats a same-cycle retire.
        issue(1, 1'b0); tick();
        issue(2, 1'b1); tick();
        issue(4, 1'b0); tick(); idle();
        sb_if.raddr1 = 5'd2;
        sb_if.raddr2 = 5'd4;
        #1;
        chk("fl_stall_before", int'(sb_if.stall), 1);
        chk("fl_inflight_before", int'(sb_if.inflight), 3);
        sb_if.flush = 1'b1;
        retire(1);
        tick(); idle();
        chk("fl_rs1_busy", int'(sb_if.rs1_busy), 0);
        chk("fl_rs2_busy", int'(sb_if.rs2_busy), 0);
        chk("fl_stall", int'(sb_if.stall), 0);
        chk("fl_inflight", int'(sb_if.inflight), 0);
        chk("fl_err", int'(sb_if.err), 0);

        // Four writers to r9: saturates at 3 and raises sticky err.
        sb_if.raddr1 = 5'd9;
        sb_if.raddr2 = 5'd0;
        issue(9, 1'b0);
        tick(); tick(); tick();
        chk("r9_err_after_3", int'(sb_if.err), 0);
        tick(); idle();
        chk("r9_err_after_4", int'(sb_if.err), 1);
        chk("r9_busy", int'(sb_if.rs1_busy), 1);
        sb_if.flush = 1'b1;
        tick(); idle();
        chk("r9_err_after_flush", int'(sb_if.err), 1);
        chk("r9_busy_after_flush", int'(sb_if.rs1_busy), 0);

        // Asynchronous reset mid-cycle with r6 pending twice.
        sb_if.raddr1 = 5'd6;
        issue(6, 1'b0);
        tick(); tick(); idle();
        chk("r6_busy", int'(sb_if.rs1_busy), 1);
        #2 resetn = 1'b0;
        #1;
        chk("arst_rs1_busy", int'(sb_if.rs1_busy), 0);
        chk("arst_inflight", int'(sb_if.inflight), 0);
        chk("arst_err", int'(sb_if.err), 0);
        issue(6, 1'b0);
        tick(); tick(); idle();
        resetn = 1'b1;
        chk("arst_ignored_busy", int'(sb_if.rs1_busy), 0);
        tick();
        chk("arst_post_busy", int'(sb_if.rs1_busy), 0);

        // Randomized traffic, reset between segments so err stays informative.
        for (int seg = 0; seg < 4; seg++) begin
            for (int cyc = 0; cyc < 300; cyc++) begin
                idle();
                if ($urandom_range(0, 1) == 1) begin
                    sb_if.issue_valid = 1'b1;
                    sb_if.issue_we    = ($urandom_range(0, 4) != 0);
                    sb_if.issue_late  = ($urandom_range(0, 2) == 0);
                    sb_if.issue_waddr = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31))
                                                                    : 5'($urandom_range(0, 6));
                end
                if ($urandom_range(0, 2) == 0) begin
                    sb_if.wb_valid = 1'b1;
                    sb_if.wb_we    = ($urandom_range(0, 4) != 0);
                    sb_if.wb_waddr = 5'(pick_reg(1'b0));
                end
                if ($urandom_range(0, 2) == 0) begin
                    sb_if.ready_valid = 1'b1;
                    sb_if.ready_waddr = 5'(pick_reg(1'b1));
                end
                sb_if.flush  = ($urandom_range(0, 39) == 0);
                sb_if.raddr1 = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31))
                                                           : 5'($urandom_range(0, 6));
                sb_if.raddr2 = 5'($urandom_range(0, 7));
                tick();
            end
            do_reset();
        end

        idle();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
